mindy_merge: RTL and testbench

- Receive-side counterpart of the Mindy fan-out interface.
- Takes one meta-data stream and one frame-data stream and re-joins them into a single packetised AXI-Stream.
- Each packet is one meta-data header beat followed by N frame-data beats, with TLAST on the final beat.
- N is carried in the low bits of the meta-data word. Sits at the consumer end of the Mindy pipeline, ahead of packet-based sinks such as a DMA or network framer.

---
 rtl/mindy_pkg.sv | 27 ++
 rtl/mindy_beat_counter.sv | 34 +++
 rtl/mindy_merge.sv | 127 ++++++++++++
 tb/tb_mindy_merge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mindy_pkg.sv
// ============================================================================
// mindy_pkg : shared states, default widths and length-field helper for Mindy
// Rev 1.0
// ============================================================================
`default_nettype none

package mindy_pkg;

    localparam int MINDY_DATA_WBITS = 512;
    localparam int MINDY_LEN_WBITS  = 16;

    typedef logic [1:0] mindy_state_t;
    localparam mindy_state_t S_IDLE = 2'd0;
    localparam mindy_state_t S_HDR  = 2'd1;
    localparam mindy_state_t S_DATA = 2'd2;

    // Returns the beat-count field held in the low len_wbits bits (up to 32).
    function automatic logic [31:0] mindy_len_field(input logic [31:0] md_low,
                                                    input int          len_wbits);
        logic [31:0] mask;
        mask = (len_wbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len_wbits) - 32'd1);
        return md_low & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mindy_beat_counter.sv
// ============================================================================
// mindy_beat_counter : loadable down-counter of remaining frame beats
// Rev 1.0
// ============================================================================
`default_nettype none

module mindy_beat_counter #(
    parameter int WBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WBITS-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [WBITS-1:0] r_remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (i_dec && (r_remaining != '0)) begin
            r_remaining <= r_remaining - WBITS'(1);
        end
    end

    assign o_last = (r_remaining == WBITS'(1));

endmodule

`default_nettype wire

// File: rtl/mindy_merge.sv
// ============================================================================
// mindy_merge : joins meta-data and frame-data streams into AXIS packets
// Optional: MINDY_MERGE_STATS_EN adds packet_count / stall_cycles outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module mindy_merge
    import mindy_pkg::*;
#(
    parameter int DATA_WBITS = MINDY_DATA_WBITS,
    parameter int LEN_WBITS  = MINDY_LEN_WBITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WBITS-1:0] AXIS_MD_IN_TDATA,
    input  logic                  AXIS_MD_IN_TVALID,
    output logic                  AXIS_MD_IN_TREADY,
    input  logic [DATA_WBITS-1:0] AXIS_FD_IN_TDATA,
    input  logic                  AXIS_FD_IN_TVALID,
    output logic                  AXIS_FD_IN_TREADY,
    output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    output logic                  AXIS_OUT_TLAST,
    input  logic                  AXIS_OUT_TREADY
`ifdef MINDY_MERGE_STATS_EN
    ,
    output logic [31:0]           packet_count,
    output logic [31:0]           stall_cycles
`endif
);

    mindy_state_t          r_state;
    logic [DATA_WBITS-1:0] r_md;
    logic [LEN_WBITS-1:0]  w_len;
    logic                  w_last;
    logic                  w_md_hs;
    logic                  w_out_hs;

    assign w_len    = LEN_WBITS'(mindy_len_field(32'(r_md), LEN_WBITS));
    assign w_md_hs  = AXIS_MD_IN_TVALID & AXIS_MD_IN_TREADY;
    assign w_out_hs = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

    mindy_beat_counter #(
        .WBITS (LEN_WBITS)
    ) u_beat_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     ((r_state == S_HDR) && w_out_hs && (w_len != '0)),
        .i_load_val (w_len),
        .i_dec      ((r_state == S_DATA) && w_out_hs),
        .o_last     (w_last)
    );

    // In S_DATA the frame stream passes straight through with no register stage.
    always_comb begin
        AXIS_MD_IN_TREADY = 1'b0;
        AXIS_FD_IN_TREADY = 1'b0;
        AXIS_OUT_TDATA    = r_md;
        AXIS_OUT_TVALID   = 1'b0;
        AXIS_OUT_TLAST    = 1'b0;
        case (r_state)
            S_IDLE: AXIS_MD_IN_TREADY = 1'b1;
            S_HDR: begin
                AXIS_OUT_TVALID = 1'b1;
                AXIS_OUT_TLAST  = (w_len == '0);
            end
            S_DATA: begin
                AXIS_OUT_TDATA    = AXIS_FD_IN_TDATA;
                AXIS_OUT_TVALID   = AXIS_FD_IN_TVALID;
                AXIS_FD_IN_TREADY = AXIS_OUT_TREADY;
                AXIS_OUT_TLAST    = w_last;
            end
            default: ;
        endcase
        if (reset) begin
            AXIS_MD_IN_TREADY = 1'b0;
            AXIS_FD_IN_TREADY = 1'b0;
            AXIS_OUT_TVALID   = 1'b0;
            AXIS_OUT_TLAST    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_md    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_hs) begin
                        r_md    <= AXIS_MD_IN_TDATA;
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_out_hs) r_state <= (w_len == '0) ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_out_hs && w_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MINDY_MERGE_STATS_EN
    logic [31:0] r_packet_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_packet_count <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_out_hs && AXIS_OUT_TLAST) r_packet_count <= r_packet_count + 32'd1;
            if (AXIS_OUT_TVALID && !AXIS_OUT_TREADY) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign packet_count = r_packet_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mindy_merge.sv
// ============================================================================
// tb_mindy_merge : directed self-checking bench for mindy_merge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mindy_merge;

    localparam int DW = 64;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] md_data, fd_data, out_data;
    logic          md_valid, md_ready, fd_valid, fd_ready;
    logic          out_valid, out_last, out_ready;
`ifdef MINDY_MERGE_STATS_EN
    logic [31:0]   pkt_cnt, stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mindy_merge #(
        .DATA_WBITS (DW),
        .LEN_WBITS  (LW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .AXIS_MD_IN_TDATA  (md_data),
        .AXIS_MD_IN_TVALID (md_valid),
        .AXIS_MD_IN_TREADY (md_ready),
        .AXIS_FD_IN_TDATA  (fd_data),
        .AXIS_FD_IN_TVALID (fd_valid),
        .AXIS_FD_IN_TREADY (fd_ready),
        .AXIS_OUT_TDATA    (out_data),
        .AXIS_OUT_TVALID   (out_valid),
        .AXIS_OUT_TLAST    (out_last),
        .AXIS_OUT_TREADY   (out_ready)
`ifdef MINDY_MERGE_STATS_EN
        ,
        .packet_count      (pkt_cnt),
        .stall_cycles      (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic l, input logic [63:0] d);
        chk({tag, "_tvalid"}, 64'(out_valid), 64'(v));
        chk({tag, "_tlast"},  64'(out_last),  64'(l));
        if (v) chk({tag, "_tdata"}, out_data, d);
    endtask

    task automatic chk_rdy(input string tag, input logic mr, input logic fr);
        chk({tag, "_md_tready"}, 64'(md_ready), 64'(mr));
        chk({tag, "_fd_tready"}, 64'(fd_ready), 64'(fr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back scenario bookkeeping
    logic [63:0] mds [3];
    logic [63:0] fds [4];
    logic [63:0] exp_d [7];
    logic        exp_l [7];
    logic [63:0] obs_d [7];
    logic        obs_l [7];
    logic [7:0]  rdy_pat;
    int          mi, fi, k, fd_hs_cnt, bad_fd, last_cnt;
    logic        s_md_hs, s_fd_hs, s_out_hs;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        md_valid  = 1'b0;
        md_data   = '0;
        fd_valid  = 1'b1;
        fd_data   = 64'hAAAA_0000_0000_000A;
        out_ready = 1'b1;
        step();
        step();

        // Reset: all handshake outputs forced low even with FD valid
        chk_rdy("reset", 1'b0, 1'b0);
        chk_out("reset", 1'b0, 1'b0, '0);

        // FD before any MD is held off
        reset = 1'b0;
        #1;
        chk_rdy("idle_fd_early", 1'b1, 1'b0);
        chk_out("idle_fd_early", 1'b0, 1'b0, '0);
        step();
        chk_rdy("idle_fd_early2", 1'b1, 1'b0);
        chk_out("idle_fd_early2", 1'b0, 1'b0, '0);

        // len=3 packet: MD, A, B, C
        md_valid = 1'b1;
        md_data  = 64'h1111_2222_3333_4443;
        step();
        md_valid = 1'b0;
        #1;
        chk_out("p3_hdr", 1'b1, 1'b0, 64'h1111_2222_3333_4443);
        chk_rdy("p3_hdr", 1'b0, 1'b0);
        step();
        chk_out("p3_A", 1'b1, 1'b0, 64'hAAAA_0000_0000_000A);
        chk_rdy("p3_A", 1'b0, 1'b1);
        step();
        fd_data  = 64'hBBBB_0000_0000_000B;
        md_valid = 1'b1;
        md_data  = 64'h2222_0000_0000_00F0;
        #1;
        chk_out("p3_B", 1'b1, 1'b0, 64'hBBBB_0000_0000_000B);
        chk_rdy("p3_B_md_held", 1'b0, 1'b1);
        step();
        fd_data = 64'hCCCC_0000_0000_000C;
        #1;
        chk_out("p3_C", 1'b1, 1'b1, 64'hCCCC_0000_0000_000C);
        step();
        fd_data = 64'hDDDD_0000_0000_000D;
        #1;
        chk_out("p3_done", 1'b0, 1'b0, '0);
        chk_rdy("p3_done", 1'b1, 1'b0);

        // len=0 header-only packet with one stall cycle
        step();
        md_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_out("p0_hdr", 1'b1, 1'b1, 64'h2222_0000_0000_00F0);
        chk_rdy("p0_hdr", 1'b0, 1'b0);
        step();
        chk_out("p0_stall", 1'b1, 1'b1, 64'h2222_0000_0000_00F0);
        chk_rdy("p0_stall", 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        chk_out("p0_done", 1'b0, 1'b0, '0);
        chk_rdy("p0_done", 1'b1, 1'b0);

        // Back-to-back len=1,2,1 with a fixed irregular ready pattern
        mds[0] = 64'hA100_0000_0000_0001;
        mds[1] = 64'hA200_0000_0000_0002;
        mds[2] = 64'hA300_0000_0000_0001;
        fds[0] = 64'hF000_0000_0000_0000;
        fds[1] = 64'hF111_0000_0000_0001;
        fds[2] = 64'hF222_0000_0000_0002;
        fds[3] = 64'hF333_0000_0000_0003;
        exp_d[0] = mds[0]; exp_l[0] = 1'b0;
        exp_d[1] = fds[0]; exp_l[1] = 1'b1;
        exp_d[2] = mds[1]; exp_l[2] = 1'b0;
        exp_d[3] = fds[1]; exp_l[3] = 1'b0;
        exp_d[4] = fds[2]; exp_l[4] = 1'b1;
        exp_d[5] = mds[2]; exp_l[5] = 1'b0;
        exp_d[6] = fds[3]; exp_l[6] = 1'b1;
        rdy_pat   = 8'b1011_0100;
        mi        = 0;
        fi        = 0;
        k         = 0;
        fd_hs_cnt = 0;
        bad_fd    = 0;
        last_cnt  = 0;
        for (int cyc = 0; cyc < 80 && k < 7; cyc++) begin
            md_valid  = (mi < 3);
            md_data   = mds[(mi < 3) ? mi : 2];
            fd_valid  = (fi < 4);
            fd_data   = fds[(fi < 4) ? fi : 3];
            out_ready = rdy_pat[cyc % 8];
            #1;
            s_md_hs  = md_valid & md_ready;
            s_fd_hs  = fd_valid & fd_ready;
            s_out_hs = out_valid & out_ready;
            if (s_out_hs) begin
                obs_d[k] = out_data;
                obs_l[k] = out_last;
                if (out_last) last_cnt++;
                k++;
            end
            if (s_fd_hs) begin
                fd_hs_cnt++;
                if (!(s_out_hs && out_data === fd_data)) bad_fd++;
            end
            step();
            if (s_md_hs) mi++;
            if (s_fd_hs) fi++;
        end
        md_valid  = 1'b0;
        fd_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b_beats", 64'(k), 64'd7);
        chk("b2b_fd_consumed", 64'(fd_hs_cnt), 64'd4);
        chk("b2b_fd_outside_data", 64'(bad_fd), 64'd0);
        chk("b2b_tlast_count", 64'(last_cnt), 64'd3);
        for (int i = 0; i < k; i++) begin
            chk($sformatf("b2b_data%0d", i), obs_d[i], exp_d[i]);
            chk($sformatf("b2b_last%0d", i), 64'(obs_l[i]), 64'(exp_l[i]));
        end

        // Reset after 2 of 5 data beats, then a clean len=1 packet
        #1;
        md_valid = 1'b1;
        md_data  = 64'h5555_0000_0000_0005;
        step();
        md_valid = 1'b0;
        fd_valid = 1'b1;
        fd_data  = 64'hE000_0000_0000_0000;
        step();
        step();
        fd_data = 64'hE111_0000_0000_0001;
        step();
        fd_data = 64'hE222_0000_0000_0002;
        reset   = 1'b1;
        #1;
        chk_out("midrst", 1'b0, 1'b0, '0);
        chk_rdy("midrst", 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk_out("midrst_after", 1'b0, 1'b0, '0);
        chk_rdy("midrst_after", 1'b1, 1'b0);
        md_valid = 1'b1;
        md_data  = 64'h6666_0000_0000_0001;
        step();
        md_valid = 1'b0;
        fd_data  = 64'h6161_0000_0000_0006;
        #1;
        chk_out("rec_hdr", 1'b1, 1'b0, 64'h6666_0000_0000_0001);
        step();
        chk_out("rec_data", 1'b1, 1'b1, 64'h6161_0000_0000_0006);
        step();
        fd_valid = 1'b0;
        #1;
        chk_out("rec_done", 1'b0, 1'b0, '0);
        chk_rdy("rec_done", 1'b1, 1'b0);

        // Maximum length (2^LW-1 = 15 beats)
        md_valid = 1'b1;
        md_data  = 64'h7777_0000_0000_000F;
        step();
        md_valid = 1'b0;
        fd_valid = 1'b1;
        #1;
        chk_out("max_hdr", 1'b1, 1'b0, 64'h7777_0000_0000_000F);
        step();
        for (int i = 0; i < 15; i++) begin
            fd_data = 64'hC000 + 64'(i);
            #1;
            chk_out($sformatf("max_beat%0d", i), 1'b1, (i == 14), 64'hC000 + 64'(i));
            step();
        end
        fd_valid = 1'b0;
        #1;
        chk_out("max_done", 1'b0, 1'b0, '0);
        chk_rdy("max_done", 1'b1, 1'b0);

`ifdef MINDY_MERGE_STATS_EN
        // Four header-only packets, 3 stall cycles on the second header
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            md_valid = 1'b1;
            md_data  = 64'h5000 + 64'(p * 16);
            step();
            md_valid = 1'b0;
            if (p == 1) begin
                out_ready = 1'b0;
                step();
                step();
                step();
                out_ready = 1'b1;
            end
            step();
        end
        #1;
        chk("stats_packet_count", 64'(pkt_cnt), 64'd4);
        chk("stats_stall_cycles", 64'(stall_cnt), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
